// File: rtl/segasys1_sndcmd_if.sv
// CPU-to-sound command port bundle: CPU write bus, 8 MHz strobe and sound-side outputs.
interface segasys1_sndcmd_if;
  logic       clk8M_en;
  logic [7:0] cpu_ad;
  logic       cpu_iorq;
  logic       cpu_wr;
  logic [7:0] cpu_do;
  logic [7:0] sndno;
  logic       sndstart;
  logic       busy;
  logic       full;
  logic       overrun;

  modport master (
    output clk8M_en, cpu_ad, cpu_iorq, cpu_wr, cpu_do,
    input  sndno, sndstart, busy, full, overrun
  );

  modport slave (
    input  clk8M_en, cpu_ad, cpu_iorq, cpu_wr, cpu_do,
    output sndno, sndstart, busy, full, overrun
  );
endinterface

// File: rtl/segasys1_sndcmd.sv
// Sound command latch: CPU OUT writes are queued and replayed as timed sndstart pulses.
// Define SNDCMD_FIFO_EN for a 4-entry FIFO; otherwise a single newest-wins holding register.
module segasys1_sndcmd #(
  parameter logic [7:0] PORT_ADR = 8'h14,
  parameter int         HOLD_CNT = 2,
  parameter int         GAP_CNT  = 2
) (
  input  logic             clk40M,
  input  logic             reset,
  segasys1_sndcmd_if.slave bus
);

  typedef enum logic [1:0] {IDLE, HOLD, GAP} state_t;

  localparam logic [3:0] HOLD_M1 = 4'(HOLD_CNT - 1);
  localparam logic [3:0] GAP_M1  = 4'(GAP_CNT - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q, cnt_d;
  logic [7:0] sndno_q, sndno_d;
  logic       sndstart_q, sndstart_d;
  logic       overrun_q, overrun_d;
  logic       wstb_q, wstb_d;

  logic       wstb;
  logic       push;
  logic       pop;
  logic       q_empty;
  logic       q_full;
  logic [7:0] q_head;
  logic       ovr_set;

  // A CPU write may be held for many cycles; only its leading edge pushes.
  always_comb begin
    wstb   = bus.cpu_iorq & bus.cpu_wr & (bus.cpu_ad == PORT_ADR);
    wstb_d = wstb;
    push   = wstb & ~wstb_q;
  end

`ifdef SNDCMD_FIFO_EN
  localparam int DEPTH = 4;

  logic [7:0] mem_q [DEPTH];
  logic [7:0] mem_d [DEPTH];
  logic [1:0] wr_ptr_q, wr_ptr_d;
  logic [1:0] rd_ptr_q, rd_ptr_d;
  logic [2:0] count_q, count_d;
  logic       wr_en;

  always_comb begin
    q_empty  = (count_q == 3'd0);
    q_full   = (count_q == 3'(DEPTH));
    q_head   = mem_q[rd_ptr_q];
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    wr_en    = push & (~q_full | pop);
    ovr_set  = push & q_full & ~pop;
    wr_ptr_d = wr_en ? wr_ptr_q + 2'd1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 2'd1 : rd_ptr_q;
    case ({wr_en, pop})
      2'b10:   count_d = count_q + 3'd1;
      2'b01:   count_d = count_q - 3'd1;
      default: count_d = count_q;
    endcase
    for (int i = 0; i < DEPTH; i++) begin
      mem_d[i] = (wr_en && (wr_ptr_q == 2'(i))) ? bus.cpu_do : mem_q[i];
    end
  end

  always_ff @(posedge clk40M or posedge reset) begin
    if (reset) begin
      wr_ptr_q <= 2'd0;
      rd_ptr_q <= 2'd0;
      count_q  <= 3'd0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= 8'h00;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= mem_d[i];
    end
  end
`else
  logic       pending_q, pending_d;
  logic [7:0] hold_q, hold_d;

  always_comb begin
    q_empty   = ~pending_q;
    q_full    = pending_q;
    q_head    = hold_q;
    // Newest byte always wins; losing an unsent one is flagged.
    ovr_set   = push & pending_q & ~pop;
    hold_d    = push ? bus.cpu_do : hold_q;
    pending_d = push | (pending_q & ~pop);
  end

  always_ff @(posedge clk40M or posedge reset) begin
    if (reset) begin
      pending_q <= 1'b0;
      hold_q    <= 8'h00;
    end else begin
      pending_q <= pending_d;
      hold_q    <= hold_d;
    end
  end
`endif

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    sndno_d    = sndno_q;
    sndstart_d = sndstart_q;
    pop        = 1'b0;
    overrun_d  = overrun_q | ovr_set;
    if (bus.clk8M_en) begin
      case (state_q)
        IDLE: begin
          if (!q_empty) begin
            pop        = 1'b1;
            sndno_d    = q_head;
            sndstart_d = 1'b1;
            cnt_d      = HOLD_M1;
            state_d    = HOLD;
          end
        end
        HOLD: begin
          if (cnt_q == 4'd0) begin
            sndstart_d = 1'b0;
            cnt_d      = GAP_M1;
            state_d    = GAP;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
        GAP: begin
          if (cnt_q == 4'd0) state_d = IDLE;
          else               cnt_d   = cnt_q - 4'd1;
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk40M or posedge reset) begin
    if (reset) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      sndno_q    <= 8'h00;
      sndstart_q <= 1'b0;
      overrun_q  <= 1'b0;
      wstb_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      sndno_q    <= sndno_d;
      sndstart_q <= sndstart_d;
      overrun_q  <= overrun_d;
      wstb_q     <= wstb_d;
    end
  end

  assign bus.sndno    = sndno_q;
  assign bus.sndstart = sndstart_q;
  assign bus.busy     = ~q_empty | (state_q != IDLE);
  assign bus.full     = q_full;
  assign bus.overrun  = overrun_q;

endmodule

// File: tb/tb_segasys1_sndcmd.sv
// Scoreboard bench for segasys1_sndcmd: expected command bytes are queued by the stimulus
// and a negedge monitor checks every sndstart pulse (byte, width, spacing).
module tb_segasys1_sndcmd;
  localparam logic [7:0] PORT = 8'h14;
  localparam int HOLD = 2;
  localparam int GAP  = 2;
  localparam int DIV  = 5;
  localparam int PERIOD_CYC = (HOLD + GAP + 1) * DIV;

  logic clk40M = 1'b0;
  logic reset  = 1'b1;

  segasys1_sndcmd_if bus();

  segasys1_sndcmd #(.PORT_ADR(PORT), .HOLD_CNT(HOLD), .GAP_CNT(GAP)) dut (
    .clk40M (clk40M),
    .reset  (reset),
    .bus    (bus)
  );

  always #5 clk40M = ~clk40M;

  int checks = 0;
  int errors = 0;
  logic [7:0] sb[$];
  int  cyc = 0;
  bit  exact_spacing = 1'b0;
  bit  last_valid = 1'b0;
  int  last_rise = 0;
  bit  in_pulse = 1'b0;
  bit  prev_start = 1'b0;
  int  hold_strobes = 0;
  logic [7:0] cur_exp = 8'h00;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end else begin
      $display("ok   %s: %0h", name, act);
    end
  endtask

  // 8 MHz enable: one cycle in DIV, changed just after the active edge.
  initial begin
    int div;
    div = 0;
    bus.clk8M_en = 1'b0;
    forever begin
      @(posedge clk40M);
      #2;
      div = (div == DIV - 1) ? 0 : div + 1;
      bus.clk8M_en = (div == 0);
    end
  end

  always @(negedge clk40M) cyc++;

  // Monitor: pops the scoreboard on every sndstart rising edge.
  always @(negedge clk40M) begin
    if (reset) begin
      in_pulse   = 1'b0;
      prev_start = 1'b0;
      last_valid = 1'b0;
    end else begin
      if (bus.sndstart && !prev_start) begin
        if (sb.size() == 0) begin
          chk("unexpected_pulse", {24'h0, bus.sndno}, 32'hFFFF_FFFF);
        end else begin
          cur_exp = sb.pop_front();
          chk("pulse_byte", {24'h0, bus.sndno}, {24'h0, cur_exp});
        end
        if (last_valid) begin
          if (exact_spacing) chk("spacing_exact", cyc - last_rise, PERIOD_CYC);
          else               chk("spacing_min", ((cyc - last_rise) >= PERIOD_CYC), 1);
        end
        last_rise    = cyc;
        last_valid   = 1'b1;
        in_pulse     = 1'b1;
        hold_strobes = 0;
      end
      if (bus.sndstart && in_pulse && bus.clk8M_en) hold_strobes++;
      if (!bus.sndstart && prev_start && in_pulse) begin
        chk("pulse_width", hold_strobes, HOLD);
        chk("sndno_stable", {24'h0, bus.sndno}, {24'h0, cur_exp});
        chk("busy_in_gap", bus.busy, 1);
        in_pulse = 1'b0;
      end
      prev_start = bus.sndstart;
    end
  end

  // Called at a negedge; returns at a negedge after one idle cycle.
  task automatic cpu_write(input logic [7:0] adr, input logic [7:0] dat, input int hold);
    bus.cpu_ad   = adr;
    bus.cpu_do   = dat;
    bus.cpu_iorq = 1'b1;
    bus.cpu_wr   = 1'b1;
    repeat (hold) @(negedge clk40M);
    bus.cpu_iorq = 1'b0;
    bus.cpu_wr   = 1'b0;
    @(negedge clk40M);
  endtask

  // Returns at the negedge just after a strobe edge.
  task automatic sync_after_strobe();
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 4 * DIV && !seen; i++) begin
      @(negedge clk40M);
      if (bus.clk8M_en) seen = 1'b1;
    end
    chk("strobe_seen", seen, 1);
    @(negedge clk40M);
  endtask

  task automatic wait_idle(input string name, input int bound);
    bit done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      @(negedge clk40M);
      if (!bus.busy && !bus.sndstart && sb.size() == 0) done = 1'b1;
    end
    chk(name, done, 1);
  endtask

  initial begin
    bit busy_seen;
    bit start_seen;
    bus.cpu_ad   = 8'h00;
    bus.cpu_do   = 8'h00;
    bus.cpu_iorq = 1'b0;
    bus.cpu_wr   = 1'b0;

    repeat (3) @(negedge clk40M);
    chk("rst_sndno", {24'h0, bus.sndno}, 0);
    chk("rst_sndstart", bus.sndstart, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_full", bus.full, 0);
    chk("rst_overrun", bus.overrun, 0);
    reset = 1'b0;
    repeat (4) @(negedge clk40M);

    // Single write
    sb.push_back(8'h5A);
    cpu_write(PORT, 8'h5A, 3);
    chk("single_busy", bus.busy, 1);
    wait_idle("single_idle", 200);
    chk("single_last_sndno", {24'h0, bus.sndno}, 32'h5A);
    chk("single_overrun", bus.overrun, 0);

    // Long write: one pulse despite 30-cycle strobe
    sb.push_back(8'h33);
    cpu_write(PORT, 8'h33, 30);
    wait_idle("long_idle", 200);
    repeat (60) @(negedge clk40M);

    // Other port: nothing happens
    busy_seen = 1'b0;
    cpu_write(8'h15, 8'h77, 3);
    for (int i = 0; i < 60; i++) begin
      @(negedge clk40M);
      busy_seen |= bus.busy;
    end
    chk("otherport_busy", busy_seen, 0);
    chk("otherport_sndno", {24'h0, bus.sndno}, 32'h33);

`ifdef SNDCMD_FIFO_EN
    // Five back-to-back writes then an overflow while full and in HOLD
    last_valid    = 1'b0;
    exact_spacing = 1'b1;
    sync_after_strobe();
    for (int i = 1; i <= 5; i++) begin
      sb.push_back(8'(i));
      cpu_write(PORT, 8'(i), 1);
    end
    chk("fifo_full", bus.full, 1);
    chk("fifo_overrun_pre", bus.overrun, 0);
    chk("fifo_in_hold", bus.sndstart, 1);
    cpu_write(PORT, 8'h06, 1);
    chk("fifo_overrun_post", bus.overrun, 1);
    wait_idle("fifo_idle", 1000);
    exact_spacing = 1'b0;
`else
    // Two writes before launch: newest wins
    sync_after_strobe();
    sb.push_back(8'h20);
    cpu_write(PORT, 8'h10, 1);
    chk("hreg_full", bus.full, 1);
    chk("hreg_overrun_pre", bus.overrun, 0);
    cpu_write(PORT, 8'h20, 1);
    chk("hreg_overrun_post", bus.overrun, 1);
    wait_idle("hreg_idle", 200);
    chk("hreg_last_sndno", {24'h0, bus.sndno}, 32'h20);
`endif

    // Reset in the middle of HOLD
    sb.push_back(8'h42);
    cpu_write(PORT, 8'h42, 2);
    start_seen = 1'b0;
    for (int i = 0; i < 50 && !start_seen; i++) begin
      @(negedge clk40M);
      if (bus.sndstart) start_seen = 1'b1;
    end
    chk("midhold_start_seen", start_seen, 1);
    #2 reset = 1'b1;
    #1;
    chk("midhold_sndstart", bus.sndstart, 0);
    chk("midhold_sndno", {24'h0, bus.sndno}, 0);
    chk("midhold_busy", bus.busy, 0);
    chk("midhold_overrun", bus.overrun, 0);
    repeat (3) @(negedge clk40M);
    reset = 1'b0;
    busy_seen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk40M);
      busy_seen |= bus.busy;
    end
    chk("postrst_busy", busy_seen, 0);

    // Operation resumes after reset
    sb.push_back(8'hC3);
    cpu_write(PORT, 8'hC3, 4);
    wait_idle("resume_idle", 200);
    chk("sb_drained", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

endmodule
